// File: rtl/keyboard_pkg.sv
// keyboard_pkg: shared key-event format, PS/2 byte constants and framer state encoding.
package keyboard_pkg;
  localparam logic [15:0] RELEASED   = 16'hF000;
  localparam logic [7:0]  PS2_EXT    = 8'hE0;
  localparam logic [7:0]  PS2_BRK    = 8'hF0;
  localparam logic [7:0]  PS2_BAT    = 8'hAA;
  localparam logic [7:0]  PS2_ACK    = 8'hFA;
  localparam logic [7:0]  PS2_RESEND = 8'hFE;
  localparam logic [7:0]  PS2_ERR0   = 8'h00;
  localparam logic [7:0]  PS2_ERR1   = 8'hFF;
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} framer_state_t;
endpackage

// File: rtl/ps2_scancode_framer_if.sv
// ps2_scancode_framer_if: receiver byte stream in, framed key events out.
interface ps2_scancode_framer_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] key_code;
  logic        key_valid;
  logic        frame_err;
  modport master(output rx_data, rx_valid, input key_code, key_valid, frame_err);
  modport slave(input rx_data, rx_valid, output key_code, key_valid, frame_err);
endinterface

// File: rtl/ps2_scancode_framer_timer.sv
// ps2_prefix_timer: loadable down-counter flagging an expired inter-byte gap.
module ps2_prefix_timer #(
  parameter int CYCLES = 650_000,
  localparam int W = CYCLES > 1 ? $clog2(CYCLES) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= W'(CYCLES - 1);
    else if (en) cnt <= cnt - W'(1);
  assign expired = en && !clr && cnt == '0;
endmodule

// File: rtl/ps2_scancode_framer.sv
// ps2_scancode_framer: sequences E0/F0 prefixes into 32-bit key events with timeout and repeat filtering.
module ps2_scancode_framer
  import keyboard_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 650_000,
  parameter int REPEAT_FILTER  = 1
) (
  input logic clk,
  input logic rst_n,
  ps2_scancode_framer_if.slave bus
);
  framer_state_t state, nxt;
  logic [15:0] held_code, code;
  logic held_vld, expired, ext_st, brk_st, prefix, bad, ign, data, rpt, emit;
  logic [7:0] b;
  assign b      = bus.rx_data;
  assign ext_st = state == EXT || state == EXT_BRK;
  assign brk_st = state == BRK || state == EXT_BRK;
  assign prefix = b == PS2_EXT || b == PS2_BRK;
  assign bad    = b == PS2_ERR0 || b == PS2_ERR1 || (brk_st && prefix) || (state == EXT && b == PS2_EXT);
  assign ign    = state == IDLE && (b == PS2_BAT || b == PS2_ACK || b == PS2_RESEND);
  assign data   = bus.rx_valid && !bad && !ign && !(!brk_st && prefix);
  assign code   = {ext_st ? PS2_EXT : 8'h00, b};
  assign rpt    = !brk_st && held_vld && code == held_code;
  assign emit   = data && !(rpt && REPEAT_FILTER != 0);
  assign nxt = !bus.rx_valid ? (expired ? IDLE : state) :
               (state == IDLE && b == PS2_EXT) ? EXT :
               (state == IDLE && b == PS2_BRK) ? BRK :
               (state == EXT && b == PS2_BRK) ? EXT_BRK : IDLE;
  // The timer reloads on every byte and idles in IDLE, so any gap is measured from the last byte.
  ps2_prefix_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk), .rst_n(rst_n), .clr(bus.rx_valid || state == IDLE), .en(state != IDLE), .expired(expired)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= IDLE;
      held_code     <= '0;
      held_vld      <= 1'b0;
      bus.key_code  <= '0;
      bus.key_valid <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      state         <= nxt;
      bus.key_valid <= emit;
      bus.frame_err <= bus.rx_valid ? bad : expired;
      if (emit) bus.key_code <= {brk_st ? RELEASED : 16'h0000, code};
      if (data && !brk_st && !rpt) begin
        held_code <= code;
        held_vld  <= 1'b1;
      end
      if (data && brk_st && code == held_code) held_vld <= 1'b0;
    end
endmodule

// File: tb/tb_ps2_scancode_framer.sv
// tb_ps2_scancode_framer: scoreboard bench driving filtered and unfiltered framers from one byte stream.
module tb_ps2_scancode_framer;
  import keyboard_pkg::*;
  localparam int T = 16;
  typedef struct {bit err; logic [31:0] code;} exp_t;
  logic clk = 0, rst_n = 0, rx_valid = 0;
  logic [7:0] rx_data = 0;
  int checks = 0, failures = 0;
  exp_t q[2][$];
  logic [31:0] last[2];
  logic [7:0] pfx[$];
  int cyc = 0, last_byte = 0;
  bit held_vld = 0;
  logic [15:0] held_code = 0;
  logic kv[2], fe[2];
  logic [31:0] kc[2];
  always #5 clk = ~clk;
  ps2_scancode_framer_if f0 (), f1 ();
  assign f0.rx_data = rx_data;
  assign f0.rx_valid = rx_valid;
  assign f1.rx_data = rx_data;
  assign f1.rx_valid = rx_valid;
  assign kv[0] = f0.key_valid;
  assign fe[0] = f0.frame_err;
  assign kc[0] = f0.key_code;
  assign kv[1] = f1.key_valid;
  assign fe[1] = f1.frame_err;
  assign kc[1] = f1.key_code;
  ps2_scancode_framer #(.TIMEOUT_CYCLES(T), .REPEAT_FILTER(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(f0));
  ps2_scancode_framer #(.TIMEOUT_CYCLES(T), .REPEAT_FILTER(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(f1));

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic push(bit err, logic [31:0] c, bit only_unfiltered);
    exp_t e;
    e.err = err;
    e.code = c;
    q[0].push_back(e);
    if (!only_unfiltered) q[1].push_back(e);
  endtask

  // Reference: a byte either extends the pending prefix list, completes it into an event, or is an error.
  task automatic model(logic [7:0] b);
    bit ext, brk;
    logic [15:0] c;
    if (b == 8'h00 || b == 8'hFF) begin
      push(1, 0, 0);
      pfx.delete();
    end else if (b == 8'hE0) begin
      if (pfx.size() == 0) pfx.push_back(b);
      else begin push(1, 0, 0); pfx.delete(); end
    end else if (b == 8'hF0) begin
      if (pfx.size() == 0 || (pfx.size() == 1 && pfx[0] == 8'hE0)) pfx.push_back(b);
      else begin push(1, 0, 0); pfx.delete(); end
    end else if (pfx.size() == 0 && (b == 8'hAA || b == 8'hFA || b == 8'hFE)) begin
    end else begin
      ext = pfx.size() > 0 && pfx[0] == 8'hE0;
      brk = pfx.size() > 0 && pfx[pfx.size()-1] == 8'hF0;
      c = {ext ? 8'hE0 : 8'h00, b};
      pfx.delete();
      if (brk) begin
        push(0, {RELEASED, c}, 0);
        if (held_vld && c == held_code) held_vld = 0;
      end else if (held_vld && c == held_code) push(0, {16'h0, c}, 1);
      else begin
        held_vld = 1;
        held_code = c;
        push(0, {16'h0, c}, 0);
      end
    end
  endtask

  task automatic drive(bit v, logic [7:0] b);
    @(negedge clk);
    rx_valid = v;
    rx_data = b;
    cyc++;
    if (v) begin
      last_byte = cyc;
      model(b);
    end else if (pfx.size() != 0 && cyc - last_byte == T) begin
      push(1, 0, 0);
      pfx.delete();
    end
  endtask

  task automatic send(logic [7:0] b, int gap);
    drive(1, b);
    repeat (gap) drive(0, 8'h00);
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        last[i] = 0;
        chk($sformatf("reset_out%0d", i), {kc[i][30:0], kv[i]} | {31'h0, fe[i]}, 0);
      end else if (kv[i] && fe[i]) begin
        checks++;
        failures++;
        $display("FAIL both_strobes%0d actual=11 required=not both", i);
      end else if (kv[i] || fe[i]) begin
        if (q[i].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected%0d actual kv=%b fe=%b code=%h required=no output", i, kv[i], fe[i], kc[i]);
        end else begin
          e = q[i].pop_front();
          chk($sformatf("kind%0d", i), {31'h0, fe[i]}, {31'h0, e.err});
          if (kv[i]) begin
            chk($sformatf("code%0d", i), kc[i], e.code);
            last[i] = e.code;
          end else chk($sformatf("hold_err%0d", i), kc[i], last[i]);
        end
      end else chk($sformatf("hold%0d", i), kc[i], last[i]);
    end
  end

  initial begin
    logic [7:0] pool[16];
    int g;
    pool = '{8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'hF0, 8'h00, 8'hFF, 8'hAA, 8'hFA,
             8'h1C, 8'h29, 8'h29, 8'h74, 8'h23, 8'h5A, 8'h00};
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1;
    send(8'h1C, 2);
    send(8'hF0, 0);
    send(8'h1C, 2);
    send(8'hE0, 0);
    send(8'hF0, 0);
    send(8'h74, 2);
    send(8'h29, 0);
    send(8'h29, 0);
    send(8'h29, 2);
    send(8'hF0, T + 3);
    send(8'h23, 2);
    send(8'hE0, 0);
    send(8'hE0, 2);
    send(8'hF0, 1);
    @(posedge clk);
    #2 rst_n = 0;
    pfx.delete();
    held_vld = 0;
    held_code = 0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1;
    send(8'h5A, 2);
    for (int n = 0; n < 400; n++) begin
      pool[15] = 8'($urandom);
      g = $urandom_range(0, 9) == 0 ? $urandom_range(T - 1, T + 2) : $urandom_range(0, 2);
      send(pool[$urandom_range(0, 15)], g);
    end
    repeat (T + 5) drive(0, 8'h00);
    chk("drain0", q[0].size(), 0);
    chk("drain1", q[1].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
